// File: rtl/rvlab_tlul_host_arb_if.sv
// TL-UL types and the bus interface for the 2:1 host arbiter.
//
// tlul_pkg: the TL-UL field widths, the request (h2d) and response (d2h) structs,
//    and arb_dbg_t, the debug view of the arbiter's registered state.
// rvlab_tlul_host_arb_if: bundles both host ports, the device-side port and the
//    debug view.
//    slave  - the arbiter side: takes host requests and device responses.
//    master - the environment side: the hosts and the device.
package tlul_pkg;
   localparam int TL_AW  = 32;
   localparam int TL_DW  = 32;
   localparam int TL_AIW = 8;
   localparam int TL_DIW = 1;
   localparam int TL_DBW = TL_DW / 8;
   localparam int TL_SZW = 2;

   localparam logic [2:0] OpPutFull       = 3'h0;
   localparam logic [2:0] OpGet           = 3'h4;
   localparam logic [2:0] OpAccessAck     = 3'h0;
   localparam logic [2:0] OpAccessAckData = 3'h1;

   typedef struct packed {
      logic              a_valid;
      logic [2:0]        a_opcode;
      logic [2:0]        a_param;
      logic [TL_SZW-1:0] a_size;
      logic [TL_AIW-1:0] a_source;
      logic [TL_AW-1:0]  a_address;
      logic [TL_DBW-1:0] a_mask;
      logic [TL_DW-1:0]  a_data;
      logic              d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic              d_valid;
      logic [2:0]        d_opcode;
      logic [2:0]        d_param;
      logic [TL_SZW-1:0] d_size;
      logic [TL_AIW-1:0] d_source;
      logic [TL_DIW-1:0] d_sink;
      logic [TL_DW-1:0]  d_data;
      logic              d_error;
      logic              a_ready;
   } tl_d2h_t;

   // Registered arbiter state. Counters are shown 3 bits wide, enough for the
   // largest supported outstanding limit of 7.
   typedef struct packed {
      logic       locked;
      logic       grant;
      logic       last;
      logic [2:0] cnt0;
      logic [2:0] cnt1;
   } arb_dbg_t;
endpackage

// Handshake rule on every channel: a transfer happens in the cycle where valid
// and ready are both 1. A sender that raised valid keeps valid and its payload
// unchanged until that cycle. Ready may depend combinationally on valid.
interface rvlab_tlul_host_arb_if;
   import tlul_pkg::*;

   tl_h2d_t  tl_h0_i;
   tl_d2h_t  tl_h0_o;
   tl_h2d_t  tl_h1_i;
   tl_d2h_t  tl_h1_o;
   tl_h2d_t  tl_d_o;
   tl_d2h_t  tl_d_i;
   arb_dbg_t dbg_o;

   modport slave  (input  tl_h0_i, tl_h1_i, tl_d_i,
                   output tl_h0_o, tl_h1_o, tl_d_o, dbg_o);
   modport master (output tl_h0_i, tl_h1_i, tl_d_i,
                   input  tl_h0_o, tl_h1_o, tl_d_o, dbg_o);
endinterface

// File: rtl/rvlab_tlul_host_arb.sv
// 2:1 TL-UL host arbiter. It merges the instruction (host 0) and data (host 1)
// ports of the CPU wrapper onto one device-side TL-UL port.
//
// Ports:
//    clk_i   - clock
//    rst_ni  - synchronous, active-low reset
//    bus     - slave modport: tl_h0_i/o, tl_h1_i/o, tl_d_o/i, dbg_o
//    idle_o  - high when neither host has a request in flight
//
// Arbitration is round-robin. A request that was offered but not yet accepted
// locks the grant until it is accepted. The requesting host is coded into the
// MSB of a_source and is used to route D responses back. Each host may have at
// most MaxOutstanding requests in flight (1..7). Payloads pass through
// combinationally, so A and D add no cycles of latency.
module rvlab_tlul_host_arb
   import tlul_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   rvlab_tlul_host_arb_if.slave  bus,
   output logic                  idle_o
);
   localparam int unsigned       CntW   = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0]   MaxCnt = CntW'(MaxOutstanding);

   typedef enum logic {StOpen = 1'b0, StLocked = 1'b1} lock_state_e;

   lock_state_e     state_q, state_d;
   logic            grant_q, grant_d;
   logic            last_q, last_d;
   logic [CntW-1:0] cnt0_q, cnt0_d;
   logic [CntW-1:0] cnt1_q, cnt1_d;

   logic    elig0, elig1, sel, a_valid, a_hs;
   logic    tgt, d_ready, d_hs;
   tl_h2d_t a_src;
   tl_d2h_t rsp;

   // A response for a host with nothing in flight is a protocol violation.
   // The counter holds at 0 instead of wrapping.
   function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt,
                                                input logic inc, input logic dec);
      logic dec_ok;
      dec_ok = dec && (cnt != '0);
      if (inc && !dec_ok)      return cnt + CntW'(1);
      else if (dec_ok && !inc) return cnt - CntW'(1);
      else                     return cnt;
   endfunction

   // Grant selection and handshake detection. Every output is forced inactive
   // while reset is asserted.
   always_comb begin
      elig0 = bus.tl_h0_i.a_valid && (cnt0_q < MaxCnt);
      elig1 = bus.tl_h1_i.a_valid && (cnt1_q < MaxCnt);
      if (state_q == StLocked)  sel = grant_q;
      else if (elig0 && elig1)  sel = ~last_q;
      else                      sel = elig1;
      a_src   = sel ? bus.tl_h1_i : bus.tl_h0_i;
      a_valid = rst_ni && (sel ? elig1 : elig0);
      a_hs    = a_valid && bus.tl_d_i.a_ready;
      tgt     = bus.tl_d_i.d_source[TL_AIW-1];
      d_ready = rst_ni && (tgt ? bus.tl_h1_i.d_ready : bus.tl_h0_i.d_ready);
      d_hs    = bus.tl_d_i.d_valid && d_ready;
   end

   always_comb begin
      bus.tl_d_o          = a_src;
      bus.tl_d_o.a_valid  = a_valid;
      bus.tl_d_o.a_source = {sel, a_src.a_source[TL_AIW-2:0]};
      bus.tl_d_o.d_ready  = d_ready;

      rsp                     = bus.tl_d_i;
      rsp.d_source[TL_AIW-1]  = 1'b0;
      rsp.d_valid             = 1'b0;
      rsp.a_ready             = 1'b0;
      bus.tl_h0_o             = rsp;
      bus.tl_h1_o             = rsp;
      bus.tl_h0_o.a_ready     = a_hs && !sel;
      bus.tl_h1_o.a_ready     = a_hs && sel;
      bus.tl_h0_o.d_valid     = rst_ni && bus.tl_d_i.d_valid && !tgt;
      bus.tl_h1_o.d_valid     = rst_ni && bus.tl_d_i.d_valid && tgt;
   end

   // Next state. An offered but unaccepted request locks the grant so that the
   // A payload stays stable. A host that withdraws its request releases the lock.
   always_comb begin
      state_d = StOpen;
      grant_d = grant_q;
      last_d  = last_q;
      if (a_valid && !bus.tl_d_i.a_ready) begin
         state_d = StLocked;
         grant_d = sel;
      end
      if (a_hs) last_d = sel;
      cnt0_d = cnt_next(cnt0_q, a_hs && !sel, d_hs && !tgt);
      cnt1_d = cnt_next(cnt1_q, a_hs && sel,  d_hs && tgt);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StOpen;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   assign idle_o = !rst_ni || ((cnt0_q == '0) && (cnt1_q == '0));

   always_comb begin
      bus.dbg_o.locked = (state_q == StLocked);
      bus.dbg_o.grant  = grant_q;
      bus.dbg_o.last   = last_q;
      bus.dbg_o.cnt0   = 3'(cnt0_q);
      bus.dbg_o.cnt1   = 3'(cnt1_q);
   end

   d_no_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(d_hs && (tgt ? (cnt1_q == '0) : (cnt0_q == '0))));
endmodule

// File: tb/tb_rvlab_tlul_host_arb.sv
// Self-checking bench for rvlab_tlul_host_arb. A reference model works from the
// arbitration rules. It tracks per-host in-flight counts, the last winner, a
// host whose offered request is still pending, and the device-side queue of
// accepted sources (exp_q). The bench runs directed scenarios first and then
// randomized traffic.
module tb_rvlab_tlul_host_arb;
   import tlul_pkg::*;

   localparam int Max = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic idle;
   always #5 clk = ~clk;

   rvlab_tlul_host_arb_if bus();

   rvlab_tlul_host_arb #(.MaxOutstanding(Max)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus),
      .idle_o (idle)
   );

   // ---------------- stimulus state ----------------
   tl_h2d_t h_req [2];
   tl_d2h_t dev;

   // ---------------- model / scoreboard ----------------
   int         m_cnt [2];
   int         m_last;
   int         m_hold;          // host whose offered request is still pending, -1 if none
   logic [7:0] exp_q [$];       // accepted device-side sources, in acceptance order
   bit         acc [2];
   bit         dhs;
   int         n_checks = 0;
   int         n_pass = 0;

   // DUT outputs captured in the most recent cycle
   tl_h2d_t  obs_d_o;
   tl_d2h_t  obs_h0, obs_h1;
   arb_dbg_t obs_dbg;
   logic     obs_idle;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic tl_h2d_t mk_req(input logic [31:0] addr, input logic src,
                                      input logic [2:0] op);
      tl_h2d_t r;
      r           = '0;
      r.a_valid   = 1'b1;
      r.a_opcode  = op;
      r.a_size    = 2'd2;
      r.a_source  = {7'b0, src};
      r.a_address = addr;
      r.a_mask    = 4'hf;
      r.a_data    = addr ^ 32'h5a5a_0000;
      r.d_ready   = 1'b1;
      return r;
   endfunction

   // ---------------- driver: one clock cycle ----------------
   // Apply the inputs, compare the outputs mid-cycle, advance the model, then
   // step to just after the next rising edge.
   task automatic cycle();
      bit e [2];
      int s;
      bit av, tgt, dr;
      tl_d2h_t tp;
      bus.tl_h0_i = h_req[0];
      bus.tl_h1_i = h_req[1];
      bus.tl_d_i  = dev;
      #4;
      obs_d_o = bus.tl_d_o; obs_h0 = bus.tl_h0_o; obs_h1 = bus.tl_h1_o;
      obs_dbg = bus.dbg_o;  obs_idle = idle;
      acc = '{0, 0};
      dhs = 0;
      if (!rst_n) begin
         check_val("rst_a_valid", obs_d_o.a_valid, 0);
         check_val("rst_a_ready", {obs_h0.a_ready, obs_h1.a_ready}, 0);
         check_val("rst_d_valid", {obs_h0.d_valid, obs_h1.d_valid}, 0);
         check_val("rst_d_ready", obs_d_o.d_ready, 0);
         check_val("rst_idle", obs_idle, 1);
         m_cnt = '{0, 0}; m_last = 1; m_hold = -1;
         exp_q.delete();
      end else begin
         for (int n = 0; n < 2; n++) e[n] = h_req[n].a_valid && (m_cnt[n] < Max);
         if (m_hold >= 0)        s = m_hold;
         else if (e[0] && e[1])  s = 1 - m_last;
         else                    s = e[1] ? 1 : 0;
         av = e[s];
         check_val("a_valid", obs_d_o.a_valid, av);
         if (av) begin
            check_val("a_source", obs_d_o.a_source, {s[0], h_req[s].a_source[6:0]});
            check_val("a_addr_data", {obs_d_o.a_address, obs_d_o.a_data},
                      {h_req[s].a_address, h_req[s].a_data});
            check_val("a_opcode", obs_d_o.a_opcode, h_req[s].a_opcode);
         end
         check_val("h0_a_ready", obs_h0.a_ready, av && (s == 0) && dev.a_ready);
         check_val("h1_a_ready", obs_h1.a_ready, av && (s == 1) && dev.a_ready);
         tgt = dev.d_source[7];
         dr  = tgt ? h_req[1].d_ready : h_req[0].d_ready;
         check_val("d_ready", obs_d_o.d_ready, dr);
         check_val("h0_d_valid", obs_h0.d_valid, dev.d_valid && !tgt);
         check_val("h1_d_valid", obs_h1.d_valid, dev.d_valid && tgt);
         if (dev.d_valid) begin
            tp = tgt ? obs_h1 : obs_h0;
            check_val("d_payload", {tp.d_data, tp.d_source, tp.d_opcode, tp.d_error},
                      {dev.d_data, 1'b0, dev.d_source[6:0], dev.d_opcode, dev.d_error});
         end
         check_val("idle", obs_idle, (m_cnt[0] == 0) && (m_cnt[1] == 0));
         check_val("dbg_cnt", {obs_dbg.cnt0, obs_dbg.cnt1}, {m_cnt[0][2:0], m_cnt[1][2:0]});
         check_val("dbg_locked", obs_dbg.locked, m_hold >= 0);
         dhs = dev.d_valid && dr;
         if (dhs) begin
            m_cnt[tgt]--;
            void'(exp_q.pop_front());
         end
         if (av && dev.a_ready) begin
            acc[s] = 1; m_cnt[s]++; m_last = s; m_hold = -1;
            exp_q.push_back({s[0], h_req[s].a_source[6:0]});
         end else if (av) m_hold = s;
         else m_hold = -1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_reply(input logic [7:0] src, input logic [31:0] data);
      dev.d_valid  = 1'b1;
      dev.d_source = src;
      dev.d_data   = data;
      dev.d_opcode = OpAccessAckData;
   endtask

   // Answer every in-flight request in order. The loop is bounded.
   task automatic drain();
      h_req[0].a_valid = 0; h_req[1].a_valid = 0;
      h_req[0].d_ready = 1; h_req[1].d_ready = 1;
      for (int i = 0; i < 64 && exp_q.size() > 0; i++) begin
         set_reply(exp_q[0], $urandom);
         cycle();
         dev.d_valid = 0;
      end
      dev.d_valid = 0;
      cycle();
      check_val("drain_idle", obs_idle, 1);
   endtask

   initial begin
      h_req[0] = '0; h_req[1] = '0; dev = '0;
      rst_n = 0;
      cycle();
      cycle();
      rst_n = 1;

      // Contention from a fresh reset: host 0 wins the first tie, then the hosts alternate.
      h_req[0] = mk_req(32'h200, 1'b0, OpGet);
      h_req[1] = mk_req(32'h300, 1'b1, OpPutFull);
      dev.a_ready = 1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_val("cont_msb", obs_d_o.a_source[7], i % 2);
      end
      drain();

      // Single host: Get from host 0, then its read reply is routed back.
      h_req[0] = mk_req(32'h100, 1'b1, OpGet);
      dev.a_ready = 1;
      cycle();
      check_val("t1_a_source", obs_d_o.a_source, 8'h01);
      check_val("t1_h0_a_ready", obs_h0.a_ready, 1);
      h_req[0].a_valid = 0;
      set_reply(8'h01, 32'hDEADBEEF);
      cycle();
      check_val("t1_d", {obs_h0.d_valid, obs_h0.d_data, obs_h0.d_source}, {1'b1, 32'hDEADBEEF, 8'h01});
      check_val("t1_h1_d_valid", obs_h1.d_valid, 0);
      dev.d_valid = 0;
      cycle();
      check_val("t1_idle", obs_idle, 1);

      // Lock: host 1 is held for 3 cycles, then host 0 is served right after it.
      h_req[0] = mk_req(32'h400, 1'b0, OpGet);
      h_req[1] = mk_req(32'h500, 1'b1, OpPutFull);
      dev.a_ready = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_val("lock_hold", {obs_d_o.a_source[7], obs_d_o.a_address}, {1'b1, 32'h500});
      end
      dev.a_ready = 1;
      cycle();
      check_val("lock_h1_hs", obs_h1.a_ready, 1);
      h_req[1].a_valid = 0;
      cycle();
      check_val("lock_h0_next", {obs_h0.a_ready, obs_d_o.a_address}, {1'b1, 32'h400});
      drain();

      // Outstanding limit on host 1.
      h_req[1] = mk_req(32'h600, 1'b1, OpPutFull);
      dev.a_ready = 1;
      cycle();
      cycle();
      h_req[0] = mk_req(32'h700, 1'b0, OpGet);
      cycle();
      check_val("lim_h1_blocked", obs_h1.a_ready, 0);
      check_val("lim_h0_served", obs_h0.a_ready, 1);
      h_req[0].a_valid = 0;
      set_reply(8'h81, 32'h1234);
      cycle();
      check_val("lim_still_blocked", {obs_h1.a_ready, obs_h1.d_valid}, 2'b01);
      dev.d_valid = 0;
      cycle();
      check_val("lim_accepted", obs_h1.a_ready, 1);
      drain();

      // A handshake and D response for host 0 in the same cycle.
      h_req[0] = mk_req(32'h800, 1'b0, OpGet);
      dev.a_ready = 1;
      cycle();
      h_req[0] = mk_req(32'h804, 1'b0, OpGet);
      set_reply(8'h00, 32'hCAFE);
      cycle();
      h_req[0].a_valid = 0; dev.d_valid = 0;
      cycle();
      check_val("sim_cnt0", {obs_idle, obs_dbg.cnt0}, {1'b0, 3'd1});
      drain();

      // Reset while host 0 has 2 in flight and host 1 holds a lock.
      h_req[0] = mk_req(32'h900, 1'b0, OpGet);
      dev.a_ready = 1;
      cycle();
      cycle();
      h_req[0].a_valid = 0;
      h_req[1] = mk_req(32'hA00, 1'b1, OpGet);
      dev.a_ready = 0;
      cycle();
      cycle();
      check_val("pre_rst_state", {obs_dbg.locked, obs_dbg.cnt0}, {1'b1, 3'd2});
      set_reply(8'h00, 32'hBAD);
      rst_n = 0;
      cycle();
      rst_n = 1;
      dev.d_valid = 0;
      h_req[1].a_valid = 0;
      cycle();
      check_val("post_rst", {obs_idle, obs_dbg.cnt0, obs_dbg.locked}, {1'b1, 3'd0, 1'b0});
      h_req[0] = mk_req(32'hB00, 1'b0, OpGet);
      h_req[1] = mk_req(32'hC00, 1'b1, OpGet);
      dev.a_ready = 1;
      cycle();
      check_val("post_rst_tie", {obs_h0.a_ready, obs_d_o.a_source[7]}, 2'b10);
      drain();

      // Randomized traffic. A host holds an offered request until it is accepted.
      for (int c = 0; c < 800; c++) begin
         for (int n = 0; n < 2; n++) begin
            if (!h_req[n].a_valid && ($urandom_range(0, 99) < 60))
               h_req[n] = mk_req($urandom & 32'hffff_fffc, 1'($urandom_range(0, 1)),
                                 $urandom_range(0, 1) ? OpGet : OpPutFull);
            h_req[n].d_ready = ($urandom_range(0, 3) != 0);
         end
         dev.a_ready = ($urandom_range(0, 99) < 60);
         if (!dev.d_valid && exp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            set_reply(exp_q[0], $urandom);
            dev.d_error = 1'($urandom_range(0, 1));
         end
         cycle();
         for (int n = 0; n < 2; n++) if (acc[n]) h_req[n].a_valid = 0;
         if (dhs) dev.d_valid = 0;
      end
      dev.d_error = 0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
